ghost_collision_ctrl: RTL
=========================

Name: ghost_collision_ctrl

Overview:
- Downstream consumer of the four ghost movers and the player mover.
- Samples player and ghost tile positions on each movement tick and detects contact: same tile, or head-on swap between adjacent tiles.
- Runs the life/round state machine: freeze, respawn request and game over.
- Its freeze and respawn outputs gate the movers and the renderer.

Parameters:
- NUM_GHOSTS, 4, number of ghost position inputs.
- X_W, 10, x coordinate width (covers 640 px).
- Y_W, 9, y coordinate width (covers 480 px).
- LIVES, 3, lives at reset or restart (1..7).
- FREEZE_TICKS, 8, ticks held in the HIT state before respawn (1..255).
- FRIGHT_TICKS, 32, ticks of frightened mode (used only with the feature; 1..255).

Ports:
- clk  in  1  system clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- tick  in  1  one-cycle movement strobe, same cycle the movers update.
- restart  in  1  one-cycle pulse; leaves OVER.
- player_x  in  X_W  player pixel x (multiple of 20).
- player_y  in  Y_W  player pixel y (multiple of 20).
- ghost_x  in  NUM_GHOSTS*X_W  packed; ghost i at [i*X_W +: X_W].
- ghost_y  in  NUM_GHOSTS*Y_W  packed; ghost i at [i*Y_W +: Y_W].
- power  in  1  power-pellet pulse (feature only).
- freeze  out  1  movers must hold position.
- respawn  out  1  one-cycle pulse; movers reload start positions.
- game_over  out  1  level high in OVER.
- lives  out  3  remaining lives.
- hit_mask  out  NUM_GHOSTS  ghosts involved in the last life-losing hit.
- fright_active  out  1  frightened mode on (feature only).
- ghost_eaten  out  NUM_GHOSTS  one-cycle pulse mask (feature only).

Behaviour:
- Reset (synchronous, active-high) values: state=PLAY, lives=LIVES, freeze=0, respawn=0, game_over=0, hit_mask=0, fright_active=0, ghost_eaten=0, prev_valid=0, counters=0.
- Reset overrides everything, including a reset asserted in the middle of HIT, RESPAWN or OVER.
- Position history:
  - On every tick, prev_player and prev_ghost[i] capture the current inputs and prev_valid is set to 1.
  - prev_valid clears on reset and on RESPAWN.
- Contact for ghost i: (gx==px and gy==py) OR (prev_valid and gx==prev_px and gy==prev_py and prev_gx==px and prev_gy==py).
- Contact is evaluated only in a PLAY cycle with tick=1. It is evaluated on that cycle's inputs, before the history updates.
- PLAY:
  - Any contact on tick cycle N moves to HIT at N+1.
  - Also at N+1: lives decrements by 1, hit_mask = contact vector, freeze=1.
  - Multiple ghosts in contact cost exactly one life.
- HIT:
  - freeze=1; counts ticks.
  - If lives==0 on entry, goes to OVER on the next cycle.
  - Otherwise, after FREEZE_TICKS ticks it goes to RESPAWN.
- RESPAWN: exactly one cycle with respawn=1 and freeze=1. Clears prev_valid and the tick counter, then returns to PLAY (freeze=0 the cycle after).
- OVER:
  - game_over=1, freeze=1; ticks are ignored.
  - restart → RESPAWN with lives reloaded to LIVES and hit_mask cleared.
- restart outside OVER is ignored.
- tick outside PLAY never evaluates contact and never updates history.
- lives never underflows: no decrement below 0.

Optional Feature:
- Macro GHOST_FRIGHT_EN.
- With the macro:
  - power in PLAY loads fright_cnt = FRIGHT_TICKS and sets fright_active. A power pulse while already active reloads the counter.
  - fright_cnt decrements per tick; fright_active drops the cycle after it reaches 0.
  - Contact while fright_active gives a one-cycle ghost_eaten pulse at N+1 with the contact mask. There is no life loss and no state change.
  - RESPAWN and OVER clear fright.
- Without the macro: power is ignored, and fright_active and ghost_eaten are tied to 0. Ports remain present.

Decomposition:
- Shared package / define file:
  - state encoding (PLAY, HIT, RESPAWN, OVER);
  - TILE_SIZE=20;
  - NUM_GHOSTS;
  - coordinate widths derived from screen width and height.
- One sub-module, tile_contact_detect: purely combinational, one instance per ghost. Inputs are current and previous positions plus prev_valid; output is a single contact bit.

Test Plan:
- Reset, then ghost0 = player = (300,200) on tick → next cycle freeze=1, lives=2, hit_mask=0001; after 8 ticks respawn pulses once; then freeze=0.
- Swap: tick A player (280,60), ghost2 (300,60); tick B player (300,60), ghost2 (280,60) → hit at B, hit_mask=0100.
- Ghost1 and ghost3 both on the player at the same tick → lives drops by exactly 1, hit_mask=1010.
- Three hits → OVER, game_over=1, lives=0; further ticks and contacts give no change; restart → respawn pulse, lives=3, game_over=0.
- Contact present while tick=0 → no hit; swap on the first tick after respawn (prev_valid=0) → no hit; reset asserted in HIT → all outputs return to reset values next cycle.
- With GHOST_FRIGHT_EN: power, then contact at tick 5 → ghost_eaten pulse, lives unchanged; after 32 ticks fright_active=0; a later contact costs a life.

Source files
------------

// File: rtl/ghost_collision_ctrl_pkg.sv
// Shared definitions for the ghost collision controller: state encoding,
// tile geometry and coordinate widths derived from the screen size.
package ghost_collision_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_PLAY    = 2'd0,
        ST_HIT     = 2'd1,
        ST_RESPAWN = 2'd2,
        ST_OVER    = 2'd3
    } state_e;

    localparam int TILE_SIZE  = 20;
    localparam int NUM_GHOSTS = 4;
    localparam int SCREEN_W   = 640;
    localparam int SCREEN_H   = 480;
    localparam int X_W        = $clog2(SCREEN_W);
    localparam int Y_W        = $clog2(SCREEN_H);
    localparam int LIVES_W    = 3;
    localparam int CNT_W      = 8;

endpackage

// File: rtl/tile_contact_detect.sv
// Combinational contact test for one ghost: same tile now, or the player and
// ghost exchanged tiles across the last tick (head-on pass-through).
module tile_contact_detect #(
    parameter int X_W = ghost_collision_ctrl_pkg::X_W,
    parameter int Y_W = ghost_collision_ctrl_pkg::Y_W
) (
    input  logic [X_W-1:0] px_i,
    input  logic [Y_W-1:0] py_i,
    input  logic [X_W-1:0] gx_i,
    input  logic [Y_W-1:0] gy_i,
    input  logic [X_W-1:0] prev_px_i,
    input  logic [Y_W-1:0] prev_py_i,
    input  logic [X_W-1:0] prev_gx_i,
    input  logic [Y_W-1:0] prev_gy_i,
    input  logic           prev_valid_i,
    output logic           contact_o
);

    logic same_tile;
    logic swapped;

    assign same_tile = (gx_i == px_i) && (gy_i == py_i);
    assign swapped   = prev_valid_i
                     && (gx_i == prev_px_i) && (gy_i == prev_py_i)
                     && (prev_gx_i == px_i) && (prev_gy_i == py_i);
    assign contact_o = same_tile | swapped;

endmodule

// File: rtl/ghost_collision_ctrl.sv
// Life/round controller: detects player-ghost contact on movement ticks and
// sequences PLAY/HIT/RESPAWN/OVER. Frightened mode is built with GHOST_FRIGHT_EN.
module ghost_collision_ctrl #(
    parameter int NUM_GHOSTS   = ghost_collision_ctrl_pkg::NUM_GHOSTS,
    parameter int X_W          = ghost_collision_ctrl_pkg::X_W,
    parameter int Y_W          = ghost_collision_ctrl_pkg::Y_W,
    parameter int LIVES        = 3,
    parameter int FREEZE_TICKS = 8,
    parameter int FRIGHT_TICKS = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      tick,
    input  logic                      restart,
    input  logic [X_W-1:0]            player_x,
    input  logic [Y_W-1:0]            player_y,
    input  logic [NUM_GHOSTS*X_W-1:0] ghost_x,
    input  logic [NUM_GHOSTS*Y_W-1:0] ghost_y,
    input  logic                      power,
    output logic                      freeze,
    output logic                      respawn,
    output logic                      game_over,
    output logic [2:0]                lives,
    output logic [NUM_GHOSTS-1:0]     hit_mask,
    output logic                      fright_active,
    output logic [NUM_GHOSTS-1:0]     ghost_eaten
);
    import ghost_collision_ctrl_pkg::*;

    localparam logic [LIVES_W-1:0] LIVES_INIT  = LIVES_W'(LIVES);
    localparam logic [CNT_W-1:0]   FREEZE_LAST = CNT_W'(FREEZE_TICKS - 1);
    localparam logic [CNT_W-1:0]   FRIGHT_LOAD = CNT_W'(FRIGHT_TICKS);

    state_e                    state_q, state_d;
    logic [LIVES_W-1:0]        lives_q, lives_d;
    logic [NUM_GHOSTS-1:0]     hit_mask_q, hit_mask_d;
    logic [CNT_W-1:0]          tick_cnt_q, tick_cnt_d;
    logic                      prev_valid_q, prev_valid_d;
    logic [X_W-1:0]            prev_px_q, prev_px_d;
    logic [Y_W-1:0]            prev_py_q, prev_py_d;
    logic [NUM_GHOSTS*X_W-1:0] prev_gx_q, prev_gx_d;
    logic [NUM_GHOSTS*Y_W-1:0] prev_gy_q, prev_gy_d;
    logic [NUM_GHOSTS-1:0]     contact;
    logic                      eval;
    logic                      fright_now;

    assign eval = tick && (state_q == ST_PLAY);

    generate
        for (genvar gi = 0; gi < NUM_GHOSTS; gi++) begin : g_det
            tile_contact_detect #(
                .X_W (X_W),
                .Y_W (Y_W)
            ) u_det (
                .px_i         (player_x),
                .py_i         (player_y),
                .gx_i         (ghost_x[gi*X_W +: X_W]),
                .gy_i         (ghost_y[gi*Y_W +: Y_W]),
                .prev_px_i    (prev_px_q),
                .prev_py_i    (prev_py_q),
                .prev_gx_i    (prev_gx_q[gi*X_W +: X_W]),
                .prev_gy_i    (prev_gy_q[gi*Y_W +: Y_W]),
                .prev_valid_i (prev_valid_q),
                .contact_o    (contact[gi])
            );
        end
    endgenerate

    always_comb begin
        state_d      = state_q;
        lives_d      = lives_q;
        hit_mask_d   = hit_mask_q;
        tick_cnt_d   = tick_cnt_q;
        prev_valid_d = prev_valid_q;
        prev_px_d    = prev_px_q;
        prev_py_d    = prev_py_q;
        prev_gx_d    = prev_gx_q;
        prev_gy_d    = prev_gy_q;

        // History captures the pre-tick inputs; contact above already used the old copy.
        if (eval) begin
            prev_valid_d = 1'b1;
            prev_px_d    = player_x;
            prev_py_d    = player_y;
            prev_gx_d    = ghost_x;
            prev_gy_d    = ghost_y;
        end

        case (state_q)
            ST_PLAY: begin
                if (eval && (|contact) && !fright_now) begin
                    state_d    = ST_HIT;
                    lives_d    = (lives_q == '0) ? '0 : lives_q - 1'b1;
                    hit_mask_d = contact;
                    tick_cnt_d = '0;
                end
            end
            ST_HIT: begin
                if (lives_q == '0) begin
                    state_d = ST_OVER;
                end else if (tick) begin
                    if (tick_cnt_q == FREEZE_LAST) begin
                        state_d = ST_RESPAWN;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            ST_RESPAWN: begin
                state_d      = ST_PLAY;
                prev_valid_d = 1'b0;
                tick_cnt_d   = '0;
            end
            ST_OVER: begin
                if (restart) begin
                    state_d    = ST_RESPAWN;
                    lives_d    = LIVES_INIT;
                    hit_mask_d = '0;
                end
            end
            default: state_d = ST_PLAY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_PLAY;
            lives_q      <= LIVES_INIT;
            hit_mask_q   <= '0;
            tick_cnt_q   <= '0;
            prev_valid_q <= 1'b0;
            prev_px_q    <= '0;
            prev_py_q    <= '0;
            prev_gx_q    <= '0;
            prev_gy_q    <= '0;
        end else begin
            state_q      <= state_d;
            lives_q      <= lives_d;
            hit_mask_q   <= hit_mask_d;
            tick_cnt_q   <= tick_cnt_d;
            prev_valid_q <= prev_valid_d;
            prev_px_q    <= prev_px_d;
            prev_py_q    <= prev_py_d;
            prev_gx_q    <= prev_gx_d;
            prev_gy_q    <= prev_gy_d;
        end
    end

`ifdef GHOST_FRIGHT_EN
    logic                  fright_active_q, fright_active_d;
    logic [CNT_W-1:0]      fright_cnt_q, fright_cnt_d;
    logic [NUM_GHOSTS-1:0] ghost_eaten_q, ghost_eaten_d;

    assign fright_now = fright_active_q;

    always_comb begin
        fright_active_d = fright_active_q;
        fright_cnt_d    = fright_cnt_q;
        ghost_eaten_d   = '0;
        if (state_q == ST_PLAY) begin
            if (power) begin
                fright_active_d = 1'b1;
                fright_cnt_d    = FRIGHT_LOAD;
            end else if (fright_active_q) begin
                // Counter sits at zero for one cycle before the mode drops.
                if (fright_cnt_q == '0) begin
                    fright_active_d = 1'b0;
                end else if (tick) begin
                    fright_cnt_d = fright_cnt_q - 1'b1;
                end
            end
            if (eval && fright_active_q) begin
                ghost_eaten_d = contact;
            end
        end else if ((state_q == ST_RESPAWN) || (state_q == ST_OVER)) begin
            fright_active_d = 1'b0;
            fright_cnt_d    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fright_active_q <= 1'b0;
            fright_cnt_q    <= '0;
            ghost_eaten_q   <= '0;
        end else begin
            fright_active_q <= fright_active_d;
            fright_cnt_q    <= fright_cnt_d;
            ghost_eaten_q   <= ghost_eaten_d;
        end
    end

    assign fright_active = fright_active_q;
    assign ghost_eaten   = ghost_eaten_q;
`else
    logic unused_fright;

    assign unused_fright = ^{power, FRIGHT_LOAD};
    assign fright_now    = 1'b0;
    assign fright_active = 1'b0;
    assign ghost_eaten   = '0;
`endif

    assign freeze    = (state_q != ST_PLAY);
    assign respawn   = (state_q == ST_RESPAWN);
    assign game_over = (state_q == ST_OVER);
    assign lives     = lives_q;
    assign hit_mask  = hit_mask_q;

endmodule
